// File: rtl/testdrive_axi4_read_dma.sv
// Read-only AXI4 master: splits an {address, beat-count} command into INCR
// read bursts (one outstanding, never crossing a 4KB page) and forwards the
// returned read data as a zero-latency ready/valid stream.
module testdrive_axi4_read_dma #(
  parameter int C_THREAD_ID_WIDTH = 1,
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_MAX_BURST       = 16,
  parameter int C_LEN_WIDTH       = 16,
  parameter logic [C_THREAD_ID_WIDTH-1:0] C_ID = '0
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         CMD_VALID,
  output logic                         CMD_READY,
  input  logic [C_ADDR_WIDTH-1:0]      CMD_ADDR,
  input  logic [C_LEN_WIDTH-1:0]       CMD_LEN,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERR,
  output logic [C_THREAD_ID_WIDTH-1:0] ARID,
  output logic [C_ADDR_WIDTH-1:0]      ARADDR,
  output logic [7:0]                   ARLEN,
  output logic [2:0]                   ARSIZE,
  output logic [1:0]                   ARBURST,
  output logic                         ARLOCK,
  output logic [3:0]                   ARCACHE,
  output logic [2:0]                   ARPROT,
  output logic                         ARVALID,
  input  logic                         ARREADY,
  input  logic [C_THREAD_ID_WIDTH-1:0] RID,
  input  logic [C_DATA_WIDTH-1:0]      RDATA,
  input  logic [1:0]                   RRESP,
  input  logic                         RLAST,
  input  logic                         RVALID,
  output logic                         RREADY,
  output logic [C_DATA_WIDTH-1:0]      DOUT_DATA,
  output logic                         DOUT_VALID,
  output logic                         DOUT_LAST,
  input  logic                         DOUT_READY
);

  localparam int SZ = $clog2(C_DATA_WIDTH / 8);
  localparam logic [C_ADDR_WIDTH-1:0] ALIGN_MASK = {C_ADDR_WIDTH{1'b1}} << SZ;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t                  state, state_nxt;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [C_LEN_WIDTH-1:0]  rem_q;
  logic [8:0]              beats_q;
  logic [8:0]              cnt_q;
  logic [7:0]              ar_len_q;
  logic                    err_q;
  logic                    err_hold_q;

  logic                    accept;
  logic                    beat;
  logic                    burst_end;
  logic [C_ADDR_WIDTH-1:0] cmd_addr_al;
  logic [C_ADDR_WIDTH-1:0] addr_nx;
  logic [C_LEN_WIDTH-1:0]  rem_nx;
  logic [8:0]              beats_cmd;
  logic [8:0]              beats_nx;

  // Burst size: limited by remaining beats, the max burst, and the room left
  // before the next 4KB page boundary (13-bit unsigned arithmetic).
  function automatic logic [8:0] calc_beats(input logic [11:0] a,
                                            input logic [C_LEN_WIDTH-1:0] rem);
    logic [12:0] room;
    logic [12:0] b;
    room = (13'd4096 - {1'b0, a}) >> SZ;
    b    = (room < 13'(C_MAX_BURST)) ? room : 13'(C_MAX_BURST);
    if (32'(rem) < 32'(b)) b = 13'(rem);
    return b[8:0];
  endfunction

  assign accept      = (state == S_IDLE) && CMD_VALID && nRST;
  assign beat        = (state == S_DATA) && RVALID && DOUT_READY;
  assign burst_end   = beat && (cnt_q == 9'd1);
  assign cmd_addr_al = CMD_ADDR & ALIGN_MASK;
  assign addr_nx     = addr_q + (C_ADDR_WIDTH'(beats_q) << SZ);
  assign rem_nx      = rem_q - C_LEN_WIDTH'(beats_q);
  assign beats_cmd   = calc_beats(cmd_addr_al[11:0], CMD_LEN);
  assign beats_nx    = calc_beats(addr_nx[11:0], rem_nx);

  // State register; reset abandons any command in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus the handshake/stream outputs derived from state.
  always_comb begin
    state_nxt  = state;
    CMD_READY  = 1'b0;
    BUSY       = (state != S_IDLE);
    DONE       = (state == S_DONE);
    ERR        = (state == S_DONE) ? err_q : err_hold_q;
    ARVALID    = (state == S_ADDR);
    RREADY     = 1'b0;
    DOUT_VALID = 1'b0;
    DOUT_LAST  = 1'b0;
    DOUT_DATA  = RDATA;
    case (state)
      S_IDLE: begin
        CMD_READY = nRST;
        if (accept) state_nxt = (CMD_LEN == '0) ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        if (ARREADY) state_nxt = S_DATA;
      end
      S_DATA: begin
        RREADY     = DOUT_READY;
        DOUT_VALID = RVALID;
        DOUT_LAST  = RLAST && (32'(rem_q) == 32'(beats_q));
        if (burst_end) state_nxt = (rem_nx == '0) ? S_DONE : S_ADDR;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command bookkeeping: address/remaining, per-burst beat counter, error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      cnt_q      <= '0;
      ar_len_q   <= '0;
      err_q      <= 1'b0;
      err_hold_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= cmd_addr_al;
            rem_q    <= CMD_LEN;
            err_q    <= 1'b0;
            beats_q  <= beats_cmd;
            ar_len_q <= 8'(beats_cmd - 9'd1);
          end
        end
        S_ADDR: begin
          if (ARREADY) cnt_q <= beats_q;
        end
        S_DATA: begin
          if (beat) begin
            cnt_q <= cnt_q - 9'd1;
            err_q <= err_q | (RRESP != 2'b00) | (RID != C_ID) |
                     (RLAST != (cnt_q == 9'd1));
          end
          if (burst_end) begin
            addr_q   <= addr_nx;
            rem_q    <= rem_nx;
            beats_q  <= beats_nx;
            ar_len_q <= 8'(beats_nx - 9'd1);
          end
        end
        S_DONE: err_hold_q <= err_q;
        default: ;
      endcase
    end
  end

  assign ARID    = C_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = ar_len_q;
  assign ARSIZE  = 3'(SZ);
  assign ARBURST = 2'b01;
  assign ARLOCK  = 1'b0;
  assign ARCACHE = 4'd0;
  assign ARPROT  = 3'd0;

endmodule

// File: tb/tb_testdrive_axi4_read_dma.sv
// Bench for testdrive_axi4_read_dma: randomized AXI read slave plus a
// burst-split / data-order reference model computed from address arithmetic.
module tb_testdrive_axi4_read_dma;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int LW = 16;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          CMD_VALID, CMD_READY;
  logic [AW-1:0] CMD_ADDR;
  logic [LW-1:0] CMD_LEN;
  logic          BUSY, DONE, ERR;
  logic [0:0]    ARID, RID;
  logic [AW-1:0] ARADDR;
  logic [7:0]    ARLEN;
  logic [2:0]    ARSIZE, ARPROT;
  logic [1:0]    ARBURST, RRESP;
  logic          ARLOCK;
  logic [3:0]    ARCACHE;
  logic          ARVALID, ARREADY;
  logic [DW-1:0] RDATA, DOUT_DATA;
  logic          RLAST, RVALID, RREADY;
  logic          DOUT_VALID, DOUT_LAST, DOUT_READY;

  always #5 CLK = ~CLK;

  testdrive_axi4_read_dma #(
    .C_THREAD_ID_WIDTH(1), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW),
    .C_MAX_BURST(16), .C_LEN_WIDTH(LW), .C_ID(1'b0)
  ) dut (
    .CLK(CLK), .nRST(nRST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .DOUT_DATA(DOUT_DATA), .DOUT_VALID(DOUT_VALID), .DOUT_LAST(DOUT_LAST),
    .DOUT_READY(DOUT_READY)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] salt = 32'h1234_5678;
  int  ar_stall_cfg = 0;
  bit  ar_rand = 0, r_rand = 0, rdy_rand = 0;
  int  inj_idx = -1;

  logic [AW+7:0] ar_q[$];
  logic [DW-1:0] d_q[$];
  bit            l_q[$];
  int            done_cnt, stab_err, fix_err, pass_err;
  bit            err_at_done;
  bit            hs_ar, hs_r;
  logic [AW-1:0] cap_addr;
  int            cap_len;

  function automatic logic [DW-1:0] pat(input logic [31:0] a);
    return {a, ~a, a ^ salt, salt};
  endfunction

  // Monitor: samples on the falling edge, records handshakes and protocol slips.
  initial begin
    logic [AW+7:0] prev;
    bit pend;
    pend = 0;
    prev = '0;
    forever begin
      @(negedge CLK);
      hs_ar = 0;
      hs_r  = 0;
      if (nRST) begin
        if (ARVALID && pend && ({ARADDR, ARLEN} !== prev)) stab_err++;
        pend = ARVALID && !ARREADY;
        prev = {ARADDR, ARLEN};
        if (ARVALID && ARREADY) begin
          hs_ar = 1;
          cap_addr = ARADDR;
          cap_len  = int'(ARLEN) + 1;
          ar_q.push_back({ARADDR, ARLEN});
          if (ARSIZE !== 3'd4 || ARBURST !== 2'b01 || ARID !== 1'b0 ||
              ARLOCK !== 1'b0 || ARCACHE !== 4'd0 || ARPROT !== 3'd0) fix_err++;
        end
        if (RVALID) begin
          if (RREADY !== DOUT_READY || DOUT_VALID !== 1'b1 || DOUT_DATA !== RDATA) pass_err++;
        end else if (DOUT_VALID !== 1'b0) pass_err++;
        if (RVALID && RREADY) hs_r = 1;
        if (DOUT_VALID && DOUT_READY) begin
          d_q.push_back(DOUT_DATA);
          l_q.push_back(DOUT_LAST);
        end
        if (DONE) begin
          done_cnt++;
          err_at_done = ERR;
        end
      end else pend = 0;
    end
  end

  // AXI read slave: one burst at a time, optional AR stall and random R gaps.
  initial begin
    logic [AW-1:0] b_addr;
    int b_len, b_i, stall_left;
    b_addr = '0; b_len = 0; b_i = 0; stall_left = 0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = 0; RLAST = 0; RID = 0; DOUT_READY = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (!nRST) begin
        b_len = 0; b_i = 0; stall_left = ar_stall_cfg;
        ARREADY = 0; RVALID = 0; RLAST = 0; RRESP = 0;
        DOUT_READY = 1;
      end else begin
        if (hs_r) begin
          b_i++;
          if (b_i == b_len) b_len = 0;
        end
        if (hs_ar) begin
          b_addr = cap_addr; b_len = cap_len; b_i = 0; stall_left = ar_stall_cfg;
        end
        if (ARVALID) begin
          if (stall_left > 0) begin
            stall_left--;
            ARREADY = 0;
          end else ARREADY = ar_rand ? 1'($urandom % 2) : 1'b1;
        end else ARREADY = 0;
        if (!(RVALID && !hs_r)) begin
          if (b_len > 0 && b_i < b_len && (!r_rand || ($urandom % 3) != 0)) begin
            RVALID = 1;
            RDATA  = pat(b_addr + 32'(b_i * 16));
            RLAST  = (b_i == b_len - 1);
            RRESP  = (d_q.size() == inj_idx) ? 2'b10 : 2'b00;
          end else begin
            RVALID = 0; RLAST = 0; RRESP = 0;
          end
        end
        DOUT_READY = rdy_rand ? 1'($urandom % 2) : 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    ar_q.delete(); d_q.delete(); l_q.delete();
    done_cnt = 0; stab_err = 0; fix_err = 0; pass_err = 0; err_at_done = 0;
  endtask

  task automatic start_cmd(input logic [31:0] a, input int len);
    bit got;
    got = 0;
    clear_mon();
    @(posedge CLK);
    #2;
    CMD_VALID = 1; CMD_ADDR = a; CMD_LEN = LW'(len);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (CMD_READY) begin got = 1; break; end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL cmd_accept: CMD_READY=0 for 200 cycles, required 1");
    end
    @(posedge CLK);
    #2;
    CMD_VALID = 0;
  endtask

  task automatic wait_done(input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < 4000; i++) begin
      if (done_cnt > 0) begin got = 1; break; end
      @(negedge CLK);
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL %s done_timeout: no DONE within 4000 cycles, required DONE", nm);
    end
    @(negedge CLK);
    compared++;
    if (DONE !== 1'b0) begin
      mismatched++;
      $display("FAIL %s done_pulse: DONE=%b one cycle later, required 0", nm, DONE);
    end
  endtask

  task automatic check_cmd(input string nm, input logic [31:0] a, input int len, input bit exp_err);
    logic [AW+7:0] exp_ar[$];
    logic [31:0] ea;
    int rem, n;
    ea  = a & ~32'hF;
    rem = len;
    while (rem > 0) begin
      int room, b;
      room = (4096 - int'(ea[11:0])) / 16;
      b = rem;
      if (b > 16) b = 16;
      if (b > room) b = room;
      exp_ar.push_back({ea, 8'(b - 1)});
      ea  = ea + 32'(b * 16);
      rem = rem - b;
    end
    compared++;
    if (ar_q.size() != exp_ar.size()) begin
      mismatched++;
      $display("FAIL %s ar_count: got %0d, required %0d", nm, ar_q.size(), exp_ar.size());
    end
    n = (ar_q.size() < exp_ar.size()) ? ar_q.size() : exp_ar.size();
    for (int i = 0; i < n; i++) begin
      compared++;
      if (ar_q[i] !== exp_ar[i]) begin
        mismatched++;
        $display("FAIL %s ar[%0d]: got addr=%h len=%0d, required addr=%h len=%0d", nm, i,
                 ar_q[i][AW+7:8], ar_q[i][7:0], exp_ar[i][AW+7:8], exp_ar[i][7:0]);
      end
    end
    compared++;
    if (d_q.size() != len) begin
      mismatched++;
      $display("FAIL %s beat_count: got %0d, required %0d", nm, d_q.size(), len);
    end
    n = (d_q.size() < len) ? d_q.size() : len;
    for (int k = 0; k < n; k++) begin
      logic [DW-1:0] ed;
      ed = pat((a & ~32'hF) + 32'(k * 16));
      compared++;
      if (d_q[k] !== ed) begin
        mismatched++;
        $display("FAIL %s data[%0d]: got %h, required %h", nm, k, d_q[k], ed);
      end
      compared++;
      if (l_q[k] != (k == len - 1)) begin
        mismatched++;
        $display("FAIL %s last[%0d]: got %0d, required %0d", nm, k, l_q[k], (k == len - 1));
      end
    end
    compared++;
    if (done_cnt != 1) begin
      mismatched++;
      $display("FAIL %s done_count: got %0d, required 1", nm, done_cnt);
    end
    compared++;
    if (err_at_done !== exp_err) begin
      mismatched++;
      $display("FAIL %s err: got %b, required %b", nm, err_at_done, exp_err);
    end
    compared++;
    if (stab_err != 0 || fix_err != 0 || pass_err != 0) begin
      mismatched++;
      $display("FAIL %s protocol: ar_unstable=%0d ar_fixed=%0d passthru=%0d, required all 0",
               nm, stab_err, fix_err, pass_err);
    end
    compared++;
    if (BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL %s busy_after: got %b, required 0", nm, BUSY);
    end
  endtask

  task automatic run(input string nm, input logic [31:0] a, input int len, input bit exp_err);
    start_cmd(a, len);
    wait_done(nm);
    check_cmd(nm, a, len, exp_err);
  endtask

  task automatic test_reset();
    nRST = 0; CMD_VALID = 0; CMD_ADDR = '0; CMD_LEN = '0;
    #12;
    compared++;
    if ({ARVALID, RREADY, BUSY, DONE, ERR, DOUT_VALID, CMD_READY} !== 7'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: ARVALID,RREADY,BUSY,DONE,ERR,DOUT_VALID,CMD_READY=%b, required 0000000",
               {ARVALID, RREADY, BUSY, DONE, ERR, DOUT_VALID, CMD_READY});
    end
    @(posedge CLK); #2; nRST = 1;
    @(negedge CLK);
    compared++;
    if (CMD_READY !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_cmd_ready: got %b, required 1", CMD_READY);
    end
  endtask

  task automatic test_single();
    salt = $urandom;
    run("single", 32'h0000_1000, 4, 0);
  endtask

  task automatic test_split();
    salt = $urandom;
    run("split4k", 32'h0000_0FC0, 8, 0);
  endtask

  task automatic test_multi();
    salt = $urandom;
    run("multi", 32'h0000_2000, 40, 0);
  endtask

  task automatic test_backpressure();
    rdy_rand = 1; r_rand = 1; ar_stall_cfg = 5;
    for (int i = 0; i < 3; i++) begin
      salt = $urandom;
      run("backpressure", $urandom, $urandom_range(20, 60), 0);
    end
    rdy_rand = 0; r_rand = 0; ar_stall_cfg = 0;
  endtask

  task automatic test_error();
    salt = $urandom;
    inj_idx = 1;
    run("rresp_err", 32'h0000_3000, 4, 1);
    compared++;
    if (ERR !== 1'b1) begin
      mismatched++;
      $display("FAIL err_hold: ERR=%b after DONE, required 1", ERR);
    end
    inj_idx = -1;
    run("clean_after_err", 32'h0000_3100, 4, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      salt = $urandom;
      ar_rand = 1'($urandom % 2); r_rand = 1'($urandom % 2); rdy_rand = 1'($urandom % 2);
      run("random", $urandom, $urandom_range(0, 50), 0);
    end
    ar_rand = 0; r_rand = 0; rdy_rand = 0;
  endtask

  task automatic test_back_to_back();
    salt = $urandom;
    start_cmd(32'h0000_5000, 0);
    @(negedge CLK);
    compared++;
    if (DONE !== 1'b1 || ar_q.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_len0: DONE=%b ars=%0d, required DONE=1 ars=0", DONE, ar_q.size());
    end
    clear_mon();
    @(posedge CLK); #2;
    CMD_VALID = 1; CMD_ADDR = 32'h0000_5040; CMD_LEN = 16'd3;
    @(negedge CLK);
    compared++;
    if (CMD_READY !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_accept: CMD_READY=%b cycle after DONE, required 1", CMD_READY);
    end
    @(posedge CLK); #2;
    CMD_VALID = 0;
    wait_done("b2b");
    check_cmd("b2b", 32'h0000_5040, 3, 0);
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    salt = $urandom;
    start_cmd(32'h0000_6000, 32);
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (d_q.size() >= 3 && RREADY === 1'b1) break;
    end
    #2;
    nRST = 0;
    #1;
    compared++;
    if ({ARVALID, RREADY, BUSY, DOUT_VALID} !== 4'b0) begin
      mismatched++;
      $display("FAIL midreset_outputs: ARVALID,RREADY,BUSY,DOUT_VALID=%b, required 0000",
               {ARVALID, RREADY, BUSY, DOUT_VALID});
    end
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (DONE !== 1'b0) saw_done = 1;
    end
    compared++;
    if (saw_done || done_cnt != 0) begin
      mismatched++;
      $display("FAIL midreset_no_done: done seen=%0d count=%0d, required 0", saw_done, done_cnt);
    end
    @(posedge CLK); #2;
    nRST = 1;
    @(negedge CLK);
    compared++;
    if (CMD_READY !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_cmd_ready: got %b, required 1", CMD_READY);
    end
    start_cmd(32'h0000_7000, 0);
    @(negedge CLK);
    compared++;
    if (DONE !== 1'b1) begin
      mismatched++;
      $display("FAIL midreset_len0_done: DONE=%b cycle after accept, required 1", DONE);
    end
    @(negedge CLK);
    compared++;
    if (ar_q.size() != 0 || done_cnt != 1 || err_at_done !== 1'b0) begin
      mismatched++;
      $display("FAIL midreset_len0: ars=%0d dones=%0d err=%b, required 0/1/0",
               ar_q.size(), done_cnt, err_at_done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_multi();
    test_backpressure();
    test_error();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
